// File: rtl/median_filter_pkg.sv
// Shared pixel and control types for the median-filter datapath.
package median_filter_pkg;

    localparam int PIXEL_T_W = 8;

    typedef logic [PIXEL_T_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/pixel_frame_source_if.sv
// Pixel stream from the frame source toward the median filter.
// Optional end-of-line marker present when PIXEL_SRC_EOL_EN is defined.
interface pixel_frame_source_if;

    median_filter_pkg::pixel_t pixel_data;
    logic                      pixel_valid;
    logic                      pixel_ready;
    logic                      pixel_sof;
`ifdef PIXEL_SRC_EOL_EN
    logic                      pixel_eol;
`endif

`ifdef PIXEL_SRC_EOL_EN
    modport master (output pixel_valid, output pixel_data, output pixel_sof,
                    output pixel_eol, input pixel_ready);
    modport slave  (input pixel_valid, input pixel_data, input pixel_sof,
                    input pixel_eol, output pixel_ready);
`else
    modport master (output pixel_valid, output pixel_data, output pixel_sof,
                    input pixel_ready);
    modport slave  (input pixel_valid, input pixel_data, input pixel_sof,
                    output pixel_ready);
`endif

endinterface

// File: rtl/pixel_frame_source.sv
// Frame source: reads a raster frame from a 1-cycle-latency frame buffer and
// streams it out through a 2-entry FIFO with valid/ready flow control.
// Optional feature macro: PIXEL_SRC_EOL_EN adds pixel_eol (last column of row).
module pixel_frame_source #(
    parameter  int IMG_W  = 8,
    parameter  int IMG_H  = 8,
    localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  median_filter_pkg::pixel_t mem_rd_data,
    pixel_frame_source_if.master      pix
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fsm_t;

    fsm_t                      state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W-1:0]         out_cnt_q, out_cnt_d;
    logic                      inflight_q, inflight_d;
    median_filter_pkg::pixel_t fifo_q [2];
    median_filter_pkg::pixel_t fifo_d [2];
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      valid;
    logic                      pop;
    logic                      push;
    logic [1:0]                room_sum;
    logic                      rd_en;

    assign valid = (count_q != 2'd0);
    assign pop   = valid && pix.pixel_ready;
    assign push  = inflight_q;

    // Occupancy credits this cycle's pop; without it a 1-cycle-latency read
    // could only be issued every other cycle.
    assign room_sum = count_q - {1'b0, pop} + {1'b0, inflight_q};
    assign rd_en    = (state_q == FETCH) && (room_sum < 2'd2);

    // Next-state, address counter, FIFO and output-counter logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        out_cnt_d  = out_cnt_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        inflight_d = rd_en;

        if (push) begin
            fifo_d[wr_ptr_q] = mem_rd_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d  = ~rd_ptr_q;
            out_cnt_d = (out_cnt_q == LAST) ? '0 : out_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (rd_en) begin
                    if (addr_q == LAST) begin
                        addr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && (out_cnt_q == LAST)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset drops any frame and in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign mem_rd_en       = rd_en;
    assign mem_rd_addr     = rd_en ? addr_q : '0;
    assign pix.pixel_valid = valid;
    assign pix.pixel_data  = valid ? fifo_q[rd_ptr_q] : '0;
    assign pix.pixel_sof   = valid && (out_cnt_q == '0);

`ifdef PIXEL_SRC_EOL_EN
    localparam int               COL_W    = $clog2(IMG_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    logic [COL_W-1:0] col_q, col_d;

    // Column of the FIFO head, advanced on every transfer.
    always_comb begin
        col_d = col_q;
        if (pop) col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end

    // Column register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) col_q <= '0;
        else     col_q <= col_d;
    end

    assign pix.pixel_eol = valid && (col_q == COL_LAST);
`endif

endmodule

// File: doc/pixel_frame_source.md
PIXEL_FRAME_SOURCE -- requirements
Module: pixel_frame_source

Interface
REQ-001 SHALL have parameter IMG_W, default 8, pixels per row (>=2).
REQ-002 SHALL have parameter IMG_H, default 8, rows per frame (>=2).
REQ-003 SHALL have derived localparam ADDR_W = $clog2(IMG_W*IMG_H), the memory address width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit; the reset is asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle frame request.
REQ-007 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle frame-complete pulse.
REQ-009 SHALL have port mem_rd_en, output, 1 bit, the frame-buffer read strobe.
REQ-010 SHALL have port mem_rd_addr, output, ADDR_W bits, the raster read address.
REQ-011 SHALL have port mem_rd_data, input, PIXEL_T_W bits (pixel_t from median_filter_pkg); read data is valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port pixel_valid, output, 1 bit, stream valid toward the median filter.
REQ-013 SHALL have port pixel_ready, input, 1 bit, stream ready from the median filter.
REQ-014 SHALL have port pixel_data, output, PIXEL_T_W bits, the pixel_t stream payload.
REQ-015 SHALL have port pixel_sof, output, 1 bit, marking the first pixel of a frame.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN and DONE as a local enum, independent of the package state_t.
REQ-017 SHALL transition IDLE->FETCH when start=1 is sampled; start SHALL be ignored in every other state.
REQ-018 SHALL in FETCH issue reads at addresses 0..IMG_W*IMG_H-1 in raster order, one address per mem_rd_en cycle.
REQ-019 SHALL assert mem_rd_en only when (output FIFO occupancy + reads in flight) < 2, so that nothing is ever dropped.
REQ-020 SHALL capture mem_rd_data into a 2-entry output FIFO on the edge after the matching mem_rd_en cycle.
REQ-021 SHALL present the FIFO head on pixel_data/pixel_valid; a transfer occurs when pixel_valid && pixel_ready.
REQ-022 SHALL keep pixel_data, pixel_sof and pixel_valid stable while pixel_valid=1 and pixel_ready=0.
REQ-023 SHALL allow a FIFO push and pop in the same cycle, with occupancy unchanged.
REQ-024 SHALL transition FETCH->DRAIN in the cycle after the read of the last address is issued.
REQ-025 SHALL transition DRAIN->DONE on the transfer of the last pixel.
REQ-026 SHALL transition DONE->IDLE unconditionally after one cycle, with done=1 only in DONE.
REQ-027 SHALL hold busy=1 in FETCH, DRAIN and DONE, and busy=0 in IDLE.
REQ-028 SHALL give the first mem_rd_en in the cycle after start is sampled, and the first pixel_valid 2 cycles after that mem_rd_en.
REQ-029 SHALL sustain 1 pixel per cycle when pixel_ready is held at 1.
REQ-030 SHALL assert pixel_sof only with pixel 0 of each frame.
REQ-031 SHALL restart the address counter at 0 for every frame, including back-to-back frames.
REQ-032 SHALL drive mem_rd_addr=0 whenever mem_rd_en=0.

Reset
REQ-033 SHALL on rst=1, at any time including mid-frame, immediately force state IDLE, empty the FIFO, clear in-flight tracking and clear the address counter.
REQ-034 SHALL drive reset values busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, pixel_valid=0, pixel_data=0 and pixel_sof=0.
REQ-035 SHALL discard any read data returning after rst and SHALL NOT emit a partial frame after reset.

Configuration
REQ-036 SHALL, when PIXEL_SRC_EOL_EN is defined, add output pixel_eol (1 bit) that is high with the last pixel of each row, i.e. column IMG_W-1.
REQ-037 SHALL, when PIXEL_SRC_EOL_EN is undefined, omit the pixel_eol port and its column counter, with all other behaviour identical.

Verification
REQ-038 SHALL cover: IMG_W=4, IMG_H=2, memory holds addr-valued pixels, ready=1, start at cycle 0 -> mem_rd_en in cycles 1-8, pixel_valid in cycles 3-10, pixels 0..7 in order, pixel_sof at cycle 3, done at cycle 11.
REQ-039 SHALL cover: pixel_ready=0 for cycles 4-8 -> mem_rd_en stops after FIFO full, no more than 2 pixels buffered, pixel_data held stable, all 8 pixels delivered with none lost or duplicated.
REQ-040 SHALL cover: start pulsed again at cycle 5 during a frame -> ignored, exactly 8 pixels, one done pulse.
REQ-041 SHALL cover: rst asserted at cycle 6 mid-frame -> all outputs 0 in that cycle, no pixel_valid until a new start, next frame starts at address 0 with pixel_sof.
REQ-042 SHALL cover: start asserted in the cycle after done -> second frame begins at address 0, pixel_sof again, 16 total pixels.
REQ-043 SHALL cover: with PIXEL_SRC_EOL_EN, IMG_W=4 -> pixel_eol high on pixels 3 and 7 only.
